operand_display: RTL and testbench

Consumer side of the lab operand path. Takes the two 16-bit operands produced by the operand-entry logic, plus the ALU result, and drives a 4-digit multiplexed seven-segment display. The value shown is selected by the same two mode switches used for operand entry. It lives at board top, between the operand/ALU datapath and the display pins.

---
 rtl/operand_display_pkg.sv | 27 ++
 rtl/operand_display_seg_hex_decode.sv | 19 +
 rtl/operand_display.sv | 141 ++++++++++++++
 tb/tb_operand_display.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/operand_display_pkg.sv
// Shared encodings and segment tables for the operand display path.
// The package itself has no configuration options.
package operand_display_pkg;

  typedef enum logic [1:0] {
    SEL_BLANK = 2'b00,
    SEL_OP1   = 2'b01,
    SEL_OP2   = 2'b10,
    SEL_RES   = 2'b11
  } sel_e;

  localparam int         NUM_DIGITS = 4;
  localparam int         IDX_W      = $clog2(NUM_DIGITS);
  localparam logic [7:0] SEG_OFF    = 8'hFF;
  localparam logic [3:0] AN_OFF     = 4'hF;

  // Active-low {dp,g,f,e,d,c,b,a} with dp off, indexed by hex digit value.
  localparam logic [7:0] SEG_HEX [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic logic [NUM_DIGITS-1:0] digit_enable(input logic [IDX_W-1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/operand_display_seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern {g..a}.
// The package table carries dp as bit 7, dropped here.
module seg_hex_decode
  import operand_display_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  logic [7:0] w_code;

  // Table lookup of the full code for the current nibble.
  always_comb begin
    w_code = SEG_HEX[i_nibble];
  end

  assign o_seg = w_code[6:0];

endmodule

// File: rtl/operand_display.sv
// Multiplexed 4-digit seven-segment driver for op1/op2/result with per-frame snapshot.
// Optional macro OPERAND_DISPLAY_BLINK_EN flashes the operand being edited.
module operand_display
  import operand_display_pkg::*;
#(
  parameter int CLK_DIV_W   = 17,
  parameter int BLINK_DIV_W = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] op1,
  input  logic [15:0] op2,
  input  logic [15:0] result,
  input  logic [1:0]  sel,
  output logic [3:0]  an,
  output logic [7:0]  seg
);

  logic [CLK_DIV_W-1:0] r_presc;
  logic                 w_tick;
  logic [IDX_W-1:0]     r_idx;
  logic                 w_frame_wrap;
  logic [15:0]          r_snap;
  sel_e                 r_snap_sel;
  logic [15:0]          w_snap_next;
  logic [3:0]           w_nibble;
  logic [6:0]           w_seg7;
  logic                 w_dp;
  logic                 w_blink;
  logic                 w_op_mode;
  logic [3:0]           w_an_next;
  logic [7:0]           w_seg_next;
  logic [3:0]           r_an;
  logic [7:0]           r_seg;

  assign w_tick       = (r_presc == {CLK_DIV_W{1'b1}});
  assign w_frame_wrap = w_tick && (r_idx == 2'd3);

  // Free-running scan prescaler.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + {{(CLK_DIV_W-1){1'b0}}, 1'b1};
    end
  end

  // Digit index advances once per scan tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= 2'd0;
    end else if (w_tick) begin
      r_idx <= r_idx + 2'd1;
    end else begin
      r_idx <= r_idx;
    end
  end

  // Source selection from live sel for the next frame.
  always_comb begin
    w_snap_next = 16'h0000;
    case (sel_e'(sel))
      SEL_OP1: w_snap_next = op1;
      SEL_OP2: w_snap_next = op2;
      SEL_RES: w_snap_next = result;
      default: w_snap_next = 16'h0000;
    endcase
  end

  // Whole-frame snapshot so mid-frame input changes never tear the display.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_snap     <= 16'h0000;
      r_snap_sel <= SEL_BLANK;
    end else if (w_frame_wrap) begin
      r_snap     <= w_snap_next;
      r_snap_sel <= sel_e'(sel);
    end else begin
      r_snap     <= r_snap;
      r_snap_sel <= r_snap_sel;
    end
  end

  assign w_nibble = r_snap[{r_idx, 2'b00} +: 4];

  seg_hex_decode u_dec (
    .i_nibble (w_nibble),
    .o_seg    (w_seg7)
  );

`ifdef OPERAND_DISPLAY_BLINK_EN
  logic [BLINK_DIV_W-1:0] r_blink;

  // Free-running blink counter; its MSB is the blank phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink <= '0;
    end else begin
      r_blink <= r_blink + {{(BLINK_DIV_W-1){1'b0}}, 1'b1};
    end
  end

  assign w_blink = r_blink[BLINK_DIV_W-1];
`else
  assign w_blink = 1'b0;
`endif

  assign w_op_mode = (r_snap_sel == SEL_OP1) || (r_snap_sel == SEL_OP2);
  assign w_dp      = ~((r_snap_sel == SEL_RES) && (r_idx == 2'd0));

  // Next display pattern from the current index and snapshot.
  always_comb begin
    w_an_next  = AN_OFF;
    w_seg_next = SEG_OFF;
    if (r_snap_sel == SEL_BLANK) begin
      w_an_next  = AN_OFF;
      w_seg_next = SEG_OFF;
    end else if (w_blink && w_op_mode) begin
      w_an_next  = AN_OFF;
      w_seg_next = SEG_OFF;
    end else begin
      w_an_next  = digit_enable(r_idx);
      w_seg_next = {w_dp, w_seg7};
    end
  end

  // Registered display pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
    end else begin
      r_an  <= w_an_next;
      r_seg <= w_seg_next;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;

endmodule

// File: tb/tb_operand_display.sv
// Directed bench for operand_display with CLK_DIV_W=4, BLINK_DIV_W=7.
// Honours OPERAND_DISPLAY_BLINK_EN in its expectations.
module tb_operand_display;

  logic        clk;
  logic        rst;
  logic [15:0] op1;
  logic [15:0] op2;
  logic [15:0] result;
  logic [1:0]  sel;
  logic [3:0]  an;
  logic [7:0]  seg;

  int checks;
  int errors;
  int edge_n;

  operand_display #(
    .CLK_DIV_W   (4),
    .BLINK_DIV_W (7)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .op1    (op1),
    .op2    (op2),
    .result (result),
    .sel    (sel),
    .an     (an),
    .seg    (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic adv();
    @(negedge clk);
    edge_n = edge_n + 1;
  endtask

  task automatic chk(input string tag, input logic [3:0] an_e, input logic [7:0] seg_e);
    checks = checks + 1;
    assert ({an, seg} === {an_e, seg_e}) else begin
      errors = errors + 1;
      $error("FAIL %s edge=%0d got an=%h seg=%h expected an=%h seg=%h",
             tag, edge_n, an, seg, an_e, seg_e);
    end
  endtask

  // Check one displayed digit, applying the blink blanking for operand modes.
  task automatic chk_disp(input string tag, input logic [3:0] an_e, input logic [7:0] seg_e,
                          input bit is_op);
    logic [3:0] a;
    logic [7:0] s;
    a = an_e;
    s = seg_e;
`ifdef OPERAND_DISPLAY_BLINK_EN
    if (is_op && (((edge_n - 1) % 128) >= 64)) begin
      a = 4'hF;
      s = 8'hFF;
    end
`else
    if (is_op) begin
      a = an_e;
    end
`endif
    chk(tag, a, s);
  endtask

  task automatic run_digit(input string tag, input logic [3:0] an_e, input logic [7:0] seg_e,
                           input bit is_op, input int n);
    for (int i = 0; i < n; i++) begin
      adv();
      chk_disp(tag, an_e, seg_e, is_op);
    end
  endtask

  task automatic run_blank(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      adv();
      chk(tag, 4'hF, 8'hFF);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    edge_n = 0;
    rst    = 1'b1;
    sel    = 2'b01;
    op1    = 16'h1234;
    op2    = 16'h0000;
    result = 16'h0000;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hold", 4'hF, 8'hFF);
    rst    = 1'b0;
    edge_n = 0;

    run_blank("post_rst_blank", 64);

    // First frame shows 1234; op1 edited mid-frame must not tear it.
    op1 = 16'h6A0F;
    run_digit("f1234_d0", 4'hE, 8'h99, 1'b1, 16);
    run_digit("f1234_d1", 4'hD, 8'hB0, 1'b1, 16);
    run_digit("f1234_d2", 4'hB, 8'hA4, 1'b1, 16);
    run_digit("f1234_d3", 4'h7, 8'hF9, 1'b1, 16);

    for (int f = 0; f < 2; f++) begin
      run_digit("op1_d0", 4'hE, 8'h8E, 1'b1, 16);
      run_digit("op1_d1", 4'hD, 8'hC0, 1'b1, 16);
      if (f == 1) begin
        sel = 2'b10;
        op2 = 16'h1111;
      end
      run_digit("op1_d2", 4'hB, 8'h88, 1'b1, 16);
      run_digit("op1_d3", 4'h7, 8'h82, 1'b1, 16);
    end

    run_digit("op2a_d0", 4'hE, 8'hF9, 1'b1, 16);
    run_digit("op2a_d1", 4'hD, 8'hF9, 1'b1, 16);
    run_digit("op2a_d2", 4'hB, 8'hF9, 1'b1, 16);
    run_digit("op2a_d3", 4'h7, 8'hF9, 1'b1, 16);

    run_digit("op2b_d0", 4'hE, 8'hF9, 1'b1, 16);
    run_digit("op2b_d1", 4'hD, 8'hF9, 1'b1, 4);
    op2 = 16'h2222;
    run_digit("atom_d1", 4'hD, 8'hF9, 1'b1, 12);
    run_digit("atom_d2", 4'hB, 8'hF9, 1'b1, 16);
    run_digit("atom_d3", 4'h7, 8'hF9, 1'b1, 16);

    run_digit("op2c_d0", 4'hE, 8'hA4, 1'b1, 16);
    run_digit("op2c_d1", 4'hD, 8'hA4, 1'b1, 16);
    sel    = 2'b11;
    result = 16'h0000;
    run_digit("op2c_d2", 4'hB, 8'hA4, 1'b1, 16);
    run_digit("op2c_d3", 4'h7, 8'hA4, 1'b1, 16);

    run_digit("res_d0", 4'hE, 8'h40, 1'b0, 16);
    run_digit("res_d1", 4'hD, 8'hC0, 1'b0, 16);
    run_digit("res_d2", 4'hB, 8'hC0, 1'b0, 16);
    run_digit("res_d3", 4'h7, 8'hC0, 1'b0, 15);
    // Sel change lands right before the wrap edge and must be captured.
    sel = 2'b00;
    run_digit("res_d3_last", 4'h7, 8'hC0, 1'b0, 1);

    run_blank("sel00_a", 32);
    sel    = 2'b11;
    result = 16'h1234;
    run_blank("sel00_b", 32);

    run_digit("res1234_d0", 4'hE, 8'h19, 1'b0, 16);
    run_digit("res1234_d1", 4'hD, 8'hB0, 1'b0, 16);
    run_digit("res1234_d2", 4'hB, 8'hA4, 1'b0, 7);

    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", 4'hF, 8'hFF);
    #4;
    rst = 1'b0;
    @(negedge clk);
    edge_n = 0;

    run_blank("rst_frame_blank", 64);
    run_digit("rst_res_d0", 4'hE, 8'h19, 1'b0, 16);
    run_digit("rst_res_d1", 4'hD, 8'hB0, 1'b0, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
